// File: rtl/riscv_pkg.sv
// Shared definitions for the pipelined RV32I core.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical bubble word, addi x0,x0,0
//   fetch_state_t : fetch request sequencer states
//   if_id_t       : contents of the IF/ID pipeline register
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,  // no request in flight, waiting to be unblocked
    REQ,   // request presented, waiting for imem ready
    WAIT   // one live request accepted, waiting for its response
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for an instruction word that returns from
// imem while decode is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : capture din (only when empty)
//   pop        : release the entry (dout is valid while full)
//   flush      : drop the entry (redirect)
//   din, dout  : IF/ID-shaped entry in / out
//   full       : entry holds a word
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  if_id_t din,
  output if_id_t dout,
  output logic   full
);

  if_id_t entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately left out of reset; 'full' qualifies it,
  // so its post-reset contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_q <= din;
    end
  end

  assign dout = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : hazard unit holds IF/ID (returning words go to the skid)
//   redirect_valid/_pc  : taken branch/jump from EX, highest priority
//   imem_req_*          : word request channel (one live request at most)
//   imem_rsp_*          : in-order response channel, >= 1 cycle after accept
//   id_valid/_ins/_pc/_pc_plus4 : IF/ID register toward decode
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_ins,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc_plus4
);

  localparam logic [WIDTH-1:0] STEP   = WIDTH'(4);
  localparam if_id_t           BUBBLE = '{valid: 1'b0, ins: NOP, pc: '0, pc_plus4: '0};

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rsp_pc_q;
  // Count of stale responses still to come back from requests orphaned by a
  // redirect. Capped at 2 by holding off new requests while it is 2.
  logic [1:0]       discard_q, discard_d;
  if_id_t           if_id_q, if_id_d;

  logic   accept;
  logic   rsp_stale;
  logic   rsp_live;
  logic   skid_full;
  if_id_t skid_out;
  if_id_t rsp_entry;

  // A redirect withdraws the pending request in the same cycle so the memory
  // never accepts a fetch from the wrong path.
  assign imem_req_valid = (state_q == REQ) && !redirect_valid && (discard_q != 2'd2);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses are in order, so stale ones always arrive before the live one.
  // Anything arriving outside WAIT (e.g. straight after reset) is ignored.
  assign rsp_stale = imem_rsp_valid && (discard_q != 2'd0);
  assign rsp_live  = imem_rsp_valid && (discard_q == 2'd0) && (state_q == WAIT) && !redirect_valid;

  assign rsp_entry = '{valid: 1'b1, ins: imem_rsp_data, pc: rsp_pc_q, pc_plus4: rsp_pc_q + STEP};

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_live && stall),
    .pop   (!stall && !redirect_valid),
    .flush (redirect_valid),
    .din   (rsp_entry),
    .dout  (skid_out),
    .full  (skid_full)
  );

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if_id_d   = if_id_q;

    if (rsp_stale) begin
      discard_d = discard_q - 2'd1;
    end

    if (redirect_valid) begin
      state_d = REQ;
      pc_d    = redirect_pc & ~WIDTH'(3);
      if_id_d = BUBBLE;
      // The live request is orphaned unless its response is arriving now.
      if (state_q == WAIT && !(imem_rsp_valid && discard_q == 2'd0)) begin
        discard_d = discard_d + 2'd1;
      end
    end else begin
      unique case (state_q)
        IDLE: if (!(stall && skid_full)) state_d = REQ;
        REQ: begin
          if (accept) begin
            state_d = WAIT;
            pc_d    = pc_q + STEP;
          end
        end
        WAIT: if (rsp_live) state_d = stall ? IDLE : REQ;
        default: state_d = IDLE;
      endcase

      if (!stall) begin
        if (skid_full) begin
          if_id_d = skid_out;
        end else if (rsp_live) begin
          if_id_d = rsp_entry;
        end else begin
          if_id_d = BUBBLE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      rsp_pc_q  <= '0;
      discard_q <= '0;
      if_id_q   <= BUBBLE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if_id_q   <= if_id_d;
      if (accept) begin
        rsp_pc_q <= pc_q;
      end
    end
  end

  assign id_valid    = if_id_q.valid;
  assign id_ins      = if_id_q.ins;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall / redirect / ready / latency traffic. The reference model is a
// program-order scoreboard: every instruction reaching decode must be the next
// sequential word after the last redirect target (or reset PC), with
// word = addr ^ 32'hA5A5_0000 as served by the bench's in-order memory.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic [31:0] id_ins, id_pc, id_pc_plus4;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ins         (id_ins),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle drive controls
  logic        stall_d = 0, redir_d = 0, ready_d = 1;
  logic [31:0] rpc_d = '0;
  int          lat_d = 1;

  // Observations
  logic        o_v, s_rv, s_acc;
  logic [31:0] o_ins, o_pc, o_pc4, s_addr;

  // In-order memory model
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cycle_n = 0;

  // Scoreboard state
  logic [31:0] exp_pc = '0;
  int          n_ins = 0;
  logic        pend = 0;
  logic [31:0] pend_addr = '0;
  logic        seen10 = 0;

  // One clock cycle: drive, sample request side at negedge, clock, check IF/ID.
  task automatic cyc();
    logic rv;
    logic p_v;
    logic [31:0] p_ins, p_pc, p_pc4;
    stall          = stall_d;
    redirect_valid = redir_d;
    redirect_pc    = rpc_d;
    imem_req_ready = ready_d;
    rv = (q_due.size() > 0) && (q_due[0] <= cycle_n);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? (q_addr[0] ^ KEY) : $urandom();
    @(negedge clk);
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_acc  = imem_req_valid && imem_req_ready;
    if (pend && !redir_d) begin
      check("req_held", 32'(s_rv), 32'd1);
      check("req_addr_stable", s_addr, pend_addr);
    end
    if (s_rv) check("req_align", 32'(s_addr[1:0]), 32'd0);
    pend      = s_rv && !imem_req_ready;
    pend_addr = s_addr;
    p_v = id_valid; p_ins = id_ins; p_pc = id_pc; p_pc4 = id_pc_plus4;
    @(posedge clk);
    #1;
    cycle_n++;
    if (rv) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (s_acc) begin
      q_addr.push_back(s_addr);
      q_due.push_back(cycle_n + lat_d - 1);
    end
    o_v = id_valid; o_ins = id_ins; o_pc = id_pc; o_pc4 = id_pc_plus4;
    if (o_v && o_pc == 32'h10) seen10 = 1;
    if (redir_d) begin
      check("flush_valid", 32'(o_v), 32'd0);
      check("flush_ins", o_ins, NOP_INSTR);
      exp_pc = rpc_d & ~32'd3;
    end else if (stall_d) begin
      check("stall_hold_valid", 32'(o_v), 32'(p_v));
      check("stall_hold_ins", o_ins, p_ins);
      check("stall_hold_pc", o_pc, p_pc);
      check("stall_hold_pc4", o_pc4, p_pc4);
    end else if (o_v) begin
      check("sb_pc", o_pc, exp_pc);
      check("sb_ins", o_ins, exp_pc ^ KEY);
      check("sb_pc4", o_pc4, exp_pc + 32'd4);
      exp_pc += 32'd4;
      n_ins++;
    end else begin
      check("bubble_ins", o_ins, NOP_INSTR);
    end
  endtask

  task automatic run_until_valid(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (o_v) break;
    end
    check({tag, "_valid_seen"}, 32'(o_v), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_id_ins"}, id_ins, NOP_INSTR);
    check({tag, "_id_pc"}, id_pc, 32'd0);
    check({tag, "_id_pc4"}, id_pc_plus4, 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_v, pc4_cyc, n0;
    first_v = -1;
    pc4_cyc = -1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1-cycle memory from reset: pc 0 then pc 4, two cycles apart
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (o_v && first_v < 0) begin
        first_v = cycle_n;
        check("first_pc", o_pc, 32'd0);
      end
      if (o_v && o_pc == 32'd4) begin
        pc4_cyc = cycle_n;
        break;
      end
    end
    check("first_valid_by_cycle3", 32'(first_v >= 0 && first_v <= 3), 32'd1);
    check("valid_period", 32'(pc4_cyc - first_v), 32'd2);

    // Stall 4 cycles while the rsp for pc=8 arrives
    stall_d = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_pc4_held", o_pc, 32'd4);
      check("stall_valid_held", 32'(o_v), 32'd1);
      if (i >= 1) check("no_req_skid_full", 32'(s_rv), 32'd0);
    end
    stall_d = 0;
    cyc();
    check("skid_release_valid", 32'(o_v), 32'd1);
    check("skid_release_pc", o_pc, 32'd8);
    check("skid_release_ins", o_ins, 32'd8 ^ KEY);

    // Redirect to 0x100 while the rsp for 0x10 is outstanding
    lat_d = 3;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (s_acc && s_addr == 32'h10) break;
    end
    check("acc_0x10", s_addr, 32'h10);
    seen10 = 0;
    redir_d = 1; rpc_d = 32'h100;
    cyc();
    redir_d = 0;
    run_until_valid(30, "redir100");
    check("redir_pc", o_pc, 32'h100);
    check("redir_pc4", o_pc4, 32'h104);
    check("no_0x10_seen", 32'(seen10), 32'd0);

    // Redirect to unaligned 0x203 together with stall
    lat_d = 1;
    run_until_valid(20, "pre_203");
    stall_d = 1; redir_d = 1; rpc_d = 32'h203;
    cyc();
    check("r203_bubble_valid", 32'(o_v), 32'd0);
    check("r203_bubble_ins", o_ins, NOP_INSTR);
    redir_d = 0;
    cyc();
    check("r203_req_valid", 32'(s_rv), 32'd1);
    check("r203_req_addr", s_addr, 32'h200);
    stall_d = 0;

    // Ready low for 5 cycles at 0x40
    ready_d = 0; redir_d = 1; rpc_d = 32'h40;
    cyc();
    redir_d = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("ready_low_valid", 32'(s_rv), 32'd1);
      check("ready_low_addr", s_addr, 32'h40);
    end
    ready_d = 1;
    cyc();
    check("ready_accept", 32'(s_acc), 32'd1);
    check("ready_accept_addr", s_addr, 32'h40);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (s_rv) break;
    end
    check("next_req_addr", s_addr, 32'h44);

    // PC wrap at 2^32
    redir_d = 1; rpc_d = 32'hFFFF_FFFC;
    cyc();
    redir_d = 0;
    run_until_valid(20, "wrap_a");
    check("wrap_pc", o_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", o_pc4, 32'h0);
    cyc();
    run_until_valid(20, "wrap_b");
    check("wrap_next_pc", o_pc, 32'h0);

    // Reset asserted mid-WAIT, stray response after release
    repeat (4) cyc();
    lat_d = 4;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (s_acc) break;
    end
    check("pre_reset_accept", 32'(s_acc), 32'd1);
    cyc();
    #2;
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    cycle_n++;
    #1;
    rst_n = 1'b1;
    pend = 0;
    exp_pc = 32'h0;
    lat_d = 1;
    ready_d = 0;
    cyc();
    cyc();
    ready_d = 1;
    run_until_valid(20, "post_reset");
    check("post_reset_pc", o_pc, 32'h0);
    check("post_reset_ins", o_ins, KEY);

    // Random traffic against the scoreboard
    n0 = n_ins;
    for (int i = 0; i < 3000; i++) begin
      stall_d = ($urandom_range(3) == 0);
      redir_d = ($urandom_range(19) == 0);
      rpc_d   = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
      ready_d = ($urandom_range(3) != 0);
      lat_d   = 1 + $urandom_range(2);
      cyc();
    end
    stall_d = 0; redir_d = 0; ready_d = 1; lat_d = 1;
    repeat (10) cyc();
    check("random_progress", 32'((n_ins - n0) > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
